// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_pkg
// Brief    : Shared funct3 constants, FSM state encoding and access checking.
// Revision : 1.0
// ============================================================================
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // An access faults on an illegal funct3, a misaligned half/word, or a word index past the end.
    function automatic logic access_err(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input int unsigned depth);
        logic bad_f3;
        logic misal;
        logic oor;
        if (we) begin
            bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end else begin
            bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        end
        misal = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        oor   = {2'b00, addr[31:2]} >= 32'(depth);
        return bad_f3 | misal | oor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Combinational byte-lane strobe/store replication and load extraction.
// Revision : 1.0
// ============================================================================
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] w_shifted;

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            2'b10: wstrb_o = 4'b1111;
            default: wstrb_o = 4'b0000;
        endcase
    end

    // Move the addressed lane down to bit 0 before extending.
    assign w_shifted = rword_i >> {addr_lo_i, 3'b000};

    always_comb begin
        rdata_o = 32'd0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    rdata_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    rdata_o = rword_i;
            F3_BU:   rdata_o = {24'd0, w_shifted[7:0]};
            F3_HU:   rdata_o = {16'd0, w_shifted[15:0]};
            default: rdata_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency RV32I data-memory responder with valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        ready_q;
    logic        busy_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          w_accept;
    logic          w_cur_we;
    logic [31:0]   w_cur_addr;
    logic [31:0]   w_cur_wdata;
    logic [2:0]    w_cur_f3;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic          w_enter_resp;
    logic          w_mem_we;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_load;
    logic [31:0]   w_resp_rdata;

    assign w_accept = req_valid && ready_q;

    // With zero latency RESP is entered on the accept edge, before the capture registers load.
    assign w_cur_we    = (state_q == IDLE) ? req_we     : we_q;
    assign w_cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    assign w_cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    assign w_cur_f3    = (state_q == IDLE) ? req_funct3 : f3_q;

    assign w_err        = access_err(w_cur_we, w_cur_f3, w_cur_addr, DEPTH_WORDS);
    assign w_idx        = w_cur_addr[AW+1:2];
    assign w_enter_resp = (state_q == IDLE && w_accept && LATENCY == 0) ||
                          (state_q == WAIT && cnt_q == 4'd1);
    assign w_mem_we     = !reset && w_enter_resp && w_cur_we && !w_err;
    assign w_resp_rdata = (w_err || w_cur_we) ? 32'd0 : w_load;

    dmem_lane_align u_align (
        .funct3_i  (w_cur_f3),
        .addr_lo_i (w_cur_addr[1:0]),
        .wdata_i   (w_cur_wdata),
        .rword_i   (mem_q[w_idx]),
        .wstrb_o   (w_wstrb),
        .wdata_o   (w_wdata_rep),
        .rdata_o   (w_load)
    );

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wstrb[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        f3_q    <= req_funct3;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // The response registers load one edge after entering RESP, after any store landed.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        rdata_q <= w_resp_rdata;
                        err_q   <= w_err;
                    end else if (resp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be: DEPTH_WORDS, default 256, the number of 32-bit memory words.
REQ-002 Parameters SHALL also include: LATENCY, default 2, the number of wait cycles between request acceptance and response (legal range 0..15).
REQ-003 Ports SHALL be:
- clk  input  1  the single clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  the MEM stage presents a request.
- req_ready  output  1  the responder accepts a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned.
- req_funct3  input  3  RV32I load/store funct3.
- resp_valid  output  1  a response is present.
- resp_ready  input  1  the pipeline consumes the response.
- resp_rdata  output  32  load result, already extended.
- resp_err  output  1  the access was misaligned, out of range, or had an illegal funct3.
- busy  output  1  a request is in flight; used for the pipeline stall.

Function
REQ-004 The block SHALL implement an FSM with three states: IDLE, WAIT and RESP.
REQ-005 req_ready SHALL equal 1 only in IDLE; a request is accepted on an edge with req_valid && req_ready, and all request fields are captured at that edge.
REQ-006 On accept, the FSM SHALL go to WAIT with the latency counter loaded to LATENCY; when LATENCY=0 it SHALL go directly to RESP.
REQ-007 In WAIT, the counter SHALL decrement each cycle; when the counter is 1, the FSM SHALL go to RESP at the next edge.
- resp_valid therefore rises exactly LATENCY+1 edges after the accept edge.
REQ-008 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL be held stable until the first edge with resp_ready=1, then the FSM SHALL return to IDLE.
- No new request is accepted at that edge.
REQ-009 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-010 Memory SHALL be little-endian.
- Word index = addr[31:2].
- Out of range when the word index >= DEPTH_WORDS.
REQ-011 Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- LB/LH sign-extend; LBU/LHU zero-extend.
- Byte and half lanes are selected by addr[1:0].
REQ-012 Stores: funct3 000 SB, 001 SH, 010 SW.
- Only the addressed lanes are written, from req_wdata[7:0], [15:0] or [31:0].
- The write occurs on the edge entering RESP.
REQ-013 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-014 Any misaligned access, out-of-range access, or illegal funct3 (011, 110, 111 for loads; any other than 000/001/010 for stores) SHALL give resp_err=1 and resp_rdata=0, with no memory write.
REQ-015 Stores SHALL also produce a response, with resp_rdata=0.
REQ-016 Outside RESP, resp_rdata SHALL be 0 and resp_err SHALL be 0.
REQ-017 Changes on req_* after the accept edge SHALL have no effect on the in-flight access.

Reset
REQ-018 While reset=1 at an edge, the FSM SHALL go to IDLE, the counter SHALL clear, and the outputs SHALL be req_ready=1 (from the edge after reset), resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
REQ-019 Reset during WAIT SHALL abort the access with no memory write and no response.
- Reset during RESP drops the response.
REQ-020 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-021 The shared package SHALL hold the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
REQ-022 One sub-module, dmem_lane_align, SHALL be purely combinational and provide two functions:
- byte-lane write-enable generation plus store-data replication;
- load lane extraction plus sign/zero extension.

Verification
REQ-023 SW then LW round trip:
- Stimulus: SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10, LATENCY=2.
- Response: resp_valid 3 edges after each accept; rdata 0xDEADBEEF; err 0.
REQ-024 Sub-word loads:
- Stimulus: after the word write above, LB 0x13, LBU 0x13, LH 0x12, LHU 0x12.
- Response: rdata 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
REQ-025 Partial store:
- Stimulus: SB 0x11 data 0x55, then LW 0x10.
- Response: rdata 0xDEAD55EF.
REQ-026 Error cases:
- LW 0x12 -> err=1, rdata=0.
- SW to word index 256 -> err=1, and a subsequent LW 0x0 is unchanged.
- funct3 011 load -> err=1.
REQ-027 Back-pressure:
- Stimulus: hold resp_ready=0 for 5 cycles in RESP while toggling req_valid.
- Response: resp_valid/rdata stable, req_ready=0, busy=1; the FSM returns to IDLE one edge after resp_ready=1.
REQ-028 Reset during an in-flight store:
- Stimulus: reset asserted in WAIT of SW 0x20 data 0x12345678.
- Response: no response; a later LW 0x20 returns the prior contents.
- Also check LATENCY=0: resp_valid on the edge after accept.
